// File: rtl/board_pkg.sv
// Board-wide constants and types shared by the push-button front-end.
package board_pkg;

  localparam int CLK_HZ = 27_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce filter and press/hold/release FSM.
//
// state   | meaning
// IDLE    | debounced level released, waiting for an accepted press
// PRESSED | button held, hold_cnt counting toward the long-press threshold
// HELD    | long_pulse already issued, hold_cnt frozen until release
module btn_channel
  import board_pkg::*;
#(
  parameter int DEB_CYCLES  = 270_000,
  parameter int LONG_CYCLES = 27_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o
);

  localparam int DEB_W  = cnt_width(DEB_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              s1_q, s2_q;
  logic              stable_q, stable_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  btn_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              pressed_q, pressed_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Any disagreement shorter than DEB_CYCLES restarts the count from zero.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (s2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pressed_d  = pressed_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stable_q) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          pressed_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        // Release is checked first so it beats a coincident long-press threshold.
        if (stable_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = HELD;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      HELD: begin
        if (stable_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        pressed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      stable_q   <= 1'b1;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      pressed_q  <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      s1_q       <= btn_n_i;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pressed_q  <= pressed_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign long_pulse_o    = long_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Push-button front-end: N_BTN independent debounced channels producing a clean
// level plus press, release and long-press strobes for downstream LED logic.
module btn_event_ctrl
  import board_pkg::*;
#(
  parameter int N_BTN       = 2,
  parameter int DEB_CYCLES  = ms_to_cycles(10),
  parameter int LONG_CYCLES = ms_to_cycles(1000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("btn_event_ctrl: DEB_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("btn_event_ctrl: LONG_CYCLES must be >= 1");
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk_i          (clk),
      .rst_i          (rst),
      .btn_n_i        (btn_n[g]),
      .pressed_o      (pressed[g]),
      .press_pulse_o  (press_pulse[g]),
      .release_pulse_o(release_pulse[g]),
      .long_pulse_o   (long_pulse[g])
    );
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl with short debounce/long-press windows; strobes are
// checked against a queue of expected (edge, channel, kind) events.
module tb_btn_event_ctrl;

  localparam int N_BTN = 2;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int K_PRESS = 0, K_RELEASE = 1, K_LONG = 2;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic             clk;
  logic             rst;
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] pressed, press_pulse, release_pulse, long_pulse;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  int   mon_n;
  logic mon_bit;

  btn_event_ctrl #(
    .N_BTN      (N_BTN),
    .DEB_CYCLES (DEB),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_PRESS:   return "press";
      K_RELEASE: return "release";
      default:   return "long";
    endcase
  endfunction

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every strobe seen must match the oldest expected event.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL strobe_missing: ch=%0d kind=%s required at edge %0d, not seen by edge %0d",
               exp_q[0].ch, kname(exp_q[0].kind), exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    for (int c = 0; c < N_BTN; c++) begin
      mon_n = 0;
      for (int k = 0; k < 3; k++) begin
        mon_bit = (k == K_PRESS) ? press_pulse[c] :
                  (k == K_RELEASE) ? release_pulse[c] : long_pulse[c];
        if (mon_bit === 1'b1) begin
          mon_n++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL strobe_unexpected: ch=%0d kind=%s at edge %0d, none required",
                     c, kname(k), cyc);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc != cyc || mon_e.ch != c || mon_e.kind != k) begin
              bad++;
              $display("FAIL strobe_match: got ch=%0d %s at edge %0d, required ch=%0d %s at edge %0d",
                       c, kname(k), cyc, mon_e.ch, kname(mon_e.kind), mon_e.cyc);
            end
          end
        end
      end
      if (mon_n > 1) begin
        total++;
        bad++;
        $display("FAIL strobe_overlap: ch=%0d has %0d strobes at edge %0d, required at most 1",
                 c, mon_n, cyc);
      end
    end
  end

  task automatic test_reset();
    rst   = 1'b1;
    btn_n = '1;
    repeat (3) @(negedge clk);
    total++;
    if ({pressed, press_pulse, release_pulse, long_pulse} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 0",
               {pressed, press_pulse, release_pulse, long_pulse});
    end
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      total++;
      if ({pressed, press_pulse, release_pulse, long_pulse} !== '0) begin
        bad++;
        $display("FAIL idle_outputs: got %b required 0 at edge %0d",
                 {pressed, press_pulse, release_pulse, long_pulse}, cyc);
      end
    end
  endtask

  task automatic check_queue_empty(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: %0d events still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clean_press();
    int k;
    logic exp_p;
    k = cyc + 1;
    btn_n[0] = 1'b0;
    push_ev(k + 6,  0, K_PRESS);
    push_ev(k + 16, 0, K_RELEASE);
    for (int t = 0; t < 22; t++) begin
      @(negedge clk);
      if (cyc == k + 9) btn_n[0] = 1'b1;
      exp_p = (cyc >= k + 6) && (cyc < k + 16);
      total++;
      if (pressed !== {1'b0, exp_p}) begin
        bad++;
        $display("FAIL clean_pressed: got %b required %b at edge %0d", pressed, {1'b0, exp_p}, cyc);
      end
    end
    check_queue_empty("clean");
  endtask

  task automatic test_glitch();
    int k;
    logic exp_p1;
    k = cyc + 1;
    btn_n = 2'b00;
    push_ev(k + 6,  1, K_PRESS);
    push_ev(k + 18, 1, K_RELEASE);
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (cyc == k + 2)  btn_n[0] = 1'b1;
      if (cyc == k + 11) btn_n[1] = 1'b1;
      exp_p1 = (cyc >= k + 6) && (cyc < k + 18);
      total++;
      if (pressed !== {exp_p1, 1'b0}) begin
        bad++;
        $display("FAIL glitch_pressed: got %b required %b at edge %0d", pressed, {exp_p1, 1'b0}, cyc);
      end
    end
    check_queue_empty("glitch");
  endtask

  task automatic test_bounce();
    int k0;
    int j;
    logic exp_p;
    k0 = cyc + 1;
    btn_n[0] = 1'b0;
    push_ev(k0 + 10, 0, K_PRESS);
    push_ev(k0 + 20, 0, K_RELEASE);
    for (int t = 0; t < 26; t++) begin
      @(negedge clk);
      j = t + 1;
      btn_n[0] = (j < 4) ? j[0] : (j < 14) ? 1'b0 : 1'b1;
      exp_p = (cyc >= k0 + 10) && (cyc < k0 + 20);
      total++;
      if (pressed[0] !== exp_p) begin
        bad++;
        $display("FAIL bounce_pressed: got %b required %b at edge %0d", pressed[0], exp_p, cyc);
      end
    end
    check_queue_empty("bounce");
  endtask

  task automatic test_long_hold();
    int k;
    logic exp_p;
    k = cyc + 1;
    btn_n[0] = 1'b0;
    push_ev(k + 6,  0, K_PRESS);
    push_ev(k + 26, 0, K_LONG);
    push_ev(k + 46, 0, K_RELEASE);
    for (int t = 0; t < 52; t++) begin
      @(negedge clk);
      if (cyc == k + 39) btn_n[0] = 1'b1;
      exp_p = (cyc >= k + 6) && (cyc < k + 46);
      total++;
      if (pressed[0] !== exp_p) begin
        bad++;
        $display("FAIL long_pressed: got %b required %b at edge %0d", pressed[0], exp_p, cyc);
      end
    end
    check_queue_empty("long");
  endtask

  task automatic test_release_race();
    int k;
    logic exp_p;
    k = cyc + 1;
    btn_n[0] = 1'b0;
    push_ev(k + 6,  0, K_PRESS);
    push_ev(k + 26, 0, K_RELEASE);
    for (int t = 0; t < 34; t++) begin
      @(negedge clk);
      if (cyc == k + 19) btn_n[0] = 1'b1;
      exp_p = (cyc >= k + 6) && (cyc < k + 26);
      total++;
      if (pressed[0] !== exp_p) begin
        bad++;
        $display("FAIL race_pressed: got %b required %b at edge %0d", pressed[0], exp_p, cyc);
      end
    end
    check_queue_empty("race");
  endtask

  task automatic test_reset_mid_hold();
    int k;
    logic exp_p;
    k = cyc + 1;
    btn_n[0] = 1'b0;
    push_ev(k + 6,  0, K_PRESS);
    push_ev(k + 20, 0, K_PRESS);
    push_ev(k + 31, 0, K_RELEASE);
    for (int t = 0; t < 37; t++) begin
      @(negedge clk);
      if (cyc == k + 12) rst = 1'b1;
      if (cyc == k + 13) begin
        total++;
        if ({pressed, press_pulse, release_pulse, long_pulse} !== '0) begin
          bad++;
          $display("FAIL midhold_reset_outputs: got %b required 0",
                   {pressed, press_pulse, release_pulse, long_pulse});
        end
        rst = 1'b0;
      end
      if (cyc == k + 24) btn_n[0] = 1'b1;
      exp_p = ((cyc >= k + 6) && (cyc < k + 13)) || ((cyc >= k + 20) && (cyc < k + 31));
      total++;
      if (pressed[0] !== exp_p) begin
        bad++;
        $display("FAIL midhold_pressed: got %b required %b at edge %0d", pressed[0], exp_p, cyc);
      end
    end
    check_queue_empty("midhold");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_long_hold();
    test_release_race();
    test_reset_mid_hold();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
